lzrw1_copy_engine: RTL and testbench

Decompressor back-end that sits directly upstream of the history buffer. It accepts decoded LZRW1 tokens (literal byte or copy item = offset + length) and expands them into a byte stream. Every emitted byte is written into the history buffer, and copy bytes are read back from it. History buffer reads are combinational; writes become visible on the next clock edge.

---
 rtl/lzrw1_copy_engine.sv | 140 ++++++++++++++
 tb/tb_lzrw1_copy_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzrw1_copy_engine.sv
// LZRW1 copy engine: expands literal/copy tokens into a byte stream,
// writing every emitted byte into the history buffer it reads copies from.
//
// Ports:
//   clock, reset        rising-edge clock, sync active-high reset
//   tok_*               token input (valid/ready), literal or offset+length
//   out_*               byte output (valid/ready)
//   hb_wr_*, hb_data_in history write port (one write per emitted byte)
//   hb_rd_addr          history read address, hb_data_out is combinational
//   err                 sticky illegal-token flag
module lzrw1_copy_engine #(
  parameter int HISTORY_SIZE = 4096,
  parameter int ENTRY_WIDTH  = 8,
  parameter int LEN_WIDTH    = 5,
  localparam int ADDR_W      = $clog2(HISTORY_SIZE)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tok_valid,
  output logic                   tok_ready,
  input  logic                   tok_is_copy,
  input  logic [ENTRY_WIDTH-1:0] tok_literal,
  input  logic [ADDR_W-1:0]      tok_offset,
  input  logic [LEN_WIDTH-1:0]   tok_length,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ENTRY_WIDTH-1:0] out_data,
  output logic                   hb_wr_en,
  output logic [ADDR_W-1:0]      hb_wr_addr,
  output logic [ENTRY_WIDTH-1:0] hb_data_in,
  output logic [ADDR_W-1:0]      hb_rd_addr,
  input  logic [ENTRY_WIDTH-1:0] hb_data_out,
  output logic                   err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LIT,
    S_COPY
  } state_t;

  localparam logic [LEN_WIDTH-1:0] MIN_LEN =
    LEN_WIDTH'(3);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN =
    LEN_WIDTH'(18);
  localparam logic [LEN_WIDTH-1:0] ONE =
    LEN_WIDTH'(1);

  state_t r_state;
  state_t w_next;

  logic [ENTRY_WIDTH-1:0] r_lit;
  logic [ADDR_W-1:0]      r_off;
  logic [LEN_WIDTH-1:0]   r_rem;
  logic [ADDR_W-1:0]      r_wr_ptr;
  logic                   r_full;
  logic                   r_err;

  logic w_acc;
  logic w_bad;
  logic w_emit;

  assign w_acc  = tok_valid & tok_ready;
  assign w_emit = out_valid & out_ready;

  // Before the first wrap, only wr_ptr bytes exist behind the pointer.
  assign w_bad = tok_is_copy & (
      (tok_length < MIN_LEN) |
      (tok_length > MAX_LEN) |
      (tok_offset == '0) |
      (!r_full & (tok_offset > r_wr_ptr)));

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc & !w_bad)
          w_next = tok_is_copy ? S_COPY : S_LIT;
      end
      S_LIT: begin
        if (out_ready) w_next = S_IDLE;
      end
      S_COPY: begin
        if (out_ready && r_rem == ONE)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tok_ready  = (r_state == S_IDLE);
    out_valid  = (r_state != S_IDLE);
    out_data   = r_lit;
    hb_rd_addr = r_wr_ptr;
    if (r_state == S_COPY) begin
      // Read pointer trails the write pointer by the fixed offset.
      hb_rd_addr = r_wr_ptr - r_off;
      out_data   = hb_data_out;
    end
    hb_wr_en   = out_valid & out_ready;
    hb_wr_addr = r_wr_ptr;
    hb_data_in = out_data;
    err        = r_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lit    <= '0;
      r_off    <= '0;
      r_rem    <= '0;
      r_wr_ptr <= '0;
      r_full   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_acc & !tok_is_copy)
        r_lit <= tok_literal;
      if (w_acc & !w_bad & tok_is_copy) begin
        r_off <= tok_offset;
        r_rem <= tok_length;
      end else if (r_state == S_COPY
                   && out_ready) begin
        r_rem <= r_rem - ONE;
      end
      if (w_acc & w_bad)
        r_err <= 1'b1;
      if (w_emit) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_wr_ptr == '1)
          r_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lzrw1_copy_engine.sv
// Testbench for lzrw1_copy_engine: byte-stream reference model feeds a
// scoreboard queue that a separate monitor checks against every emit.
module tb_lzrw1_copy_engine;

  localparam int HS = 4096;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tok_valid = 1'b0;
  logic          tok_is_copy = 1'b0;
  logic [7:0]    tok_literal = '0;
  logic [AW-1:0] tok_offset = '0;
  logic [4:0]    tok_length = '0;
  logic          out_ready = 1'b1;
  logic          tok_ready;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          hb_wr_en;
  logic [AW-1:0] hb_wr_addr;
  logic [7:0]    hb_data_in;
  logic [AW-1:0] hb_rd_addr;
  logic [7:0]    hb_data_out;
  logic          err;

  lzrw1_copy_engine dut (
    .clock       (clock),
    .reset       (reset),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_is_copy (tok_is_copy),
    .tok_literal (tok_literal),
    .tok_offset  (tok_offset),
    .tok_length  (tok_length),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .hb_wr_en    (hb_wr_en),
    .hb_wr_addr  (hb_wr_addr),
    .hb_data_in  (hb_data_in),
    .hb_rd_addr  (hb_rd_addr),
    .hb_data_out (hb_data_out),
    .err         (err)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [HS];
  always @(posedge clock)
    if (hb_wr_en) mem[hb_wr_addr] <= hb_data_in;
  assign hb_data_out = mem[hb_rd_addr];

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 0;
  logic [7:0]  stream [$];
  logic [19:0] expq [$];
  bit m_err = 1'b0;

  task automatic chk(input string name,
                     input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = ~out_ready;
    endcase
  end

  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data),
            int'(prev_data));
      end
      if (out_valid && out_ready) begin
        chk("emit_expected",
            int'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          logic [19:0] e;
          e = expq.pop_front();
          chk("hb_wr_en", int'(hb_wr_en), 1);
          chk("wr_addr", int'(hb_wr_addr),
              int'(e[19:8]));
          chk("out_data", int'(out_data),
              int'(e[7:0]));
          chk("hb_data_in", int'(hb_data_in),
              int'(e[7:0]));
        end
      end else begin
        chk("spurious_write", int'(hb_wr_en), 0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Reference: the output is a plain byte list; a copy byte is the
  // byte emitted `off` positions earlier in that list.
  task automatic model(input bit cp,
                       input logic [7:0] lit,
                       input int off, input int len,
                       output int nb);
    int t;
    t = stream.size();
    nb = 0;
    if (!cp) begin
      expq.push_back({AW'(t % HS), lit});
      stream.push_back(lit);
      nb = 1;
    end else if (len < 3 || len > 18 || off == 0 ||
                 (t < HS && off > t)) begin
      m_err = 1'b1;
    end else begin
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        int p;
        p = stream.size();
        b = stream[p - off];
        expq.push_back({AW'(p % HS), b});
        stream.push_back(b);
      end
      nb = len;
    end
  endtask

  task automatic send(input bit cp,
                      input logic [7:0] lit,
                      input int off, input int len);
    int nb;
    int n;
    model(cp, lit, off, len, nb);
    tok_is_copy = cp;
    tok_literal = lit;
    tok_offset  = AW'(off);
    tok_length  = 5'(len);
    tok_valid   = 1'b1;
    n = 0;
    while (!tok_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("tok_ready_wait", int'(tok_ready), 1);
    @(posedge clock);
    #1 tok_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!tok_ready && n < 200);
    chk("token_done", int'(tok_ready), 1);
    if (rdy_mode == 0)
      chk("token_cycles", n, 1 + nb);
    chk("err", int'(err), int'(m_err));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tok_valid = 1'b0;
    expq.delete();
    stream.delete();
    m_err = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_tok_ready", int'(tok_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_hb_wr_en", int'(hb_wr_en), 0);
    chk("rst_wr_ptr", int'(hb_wr_addr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_err", int'(err), 0);
  endtask

  initial begin
    int nb;
    do_reset();

    send(0, 8'h41, 0, 0);
    send(0, 8'h42, 0, 0);
    send(0, 8'h43, 0, 0);

    do_reset();
    send(0, 8'h41, 0, 0);
    send(1, 8'h00, 1, 5);
    chk("wr_ptr_after_copy", int'(hb_wr_addr), 6);

    for (int m = 0; m < 3; m += 2) begin
      rdy_mode = m;
      do_reset();
      send(0, 8'd10, 0, 0);
      send(0, 8'd20, 0, 0);
      send(0, 8'd30, 0, 0);
      send(1, 8'd0, 3, 4);
    end
    rdy_mode = 0;

    do_reset();
    send(0, 8'h01, 0, 0);
    send(0, 8'h02, 0, 0);
    send(1, 8'h00, 5, 3);
    do_reset();
    send(0, 8'h03, 0, 0);
    send(1, 8'h00, 1, 2);
    do_reset();
    send(0, 8'h04, 0, 0);
    send(1, 8'h00, 0, 3);

    do_reset();
    for (int i = 0; i < 4094; i++)
      send(0, 8'($urandom), 0, 0);
    send(1, 8'h00, 2, 4);
    send(1, 8'h00, 4000, 3);

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)
        send(0, 8'($urandom), 0, 0);
      else if (r < 7)
        send(1, 8'h00, $urandom_range(1, 20),
             $urandom_range(3, 18));
      else if (r < 9)
        send(1, 8'h00, $urandom_range(1, HS - 1),
             $urandom_range(3, 18));
      else if ($urandom_range(0, 1) == 0)
        send(1, 8'h00, 0, $urandom_range(3, 18));
      else
        send(1, 8'h00, $urandom_range(1, 9),
             $urandom_range(19, 31));
    end
    rdy_mode = 0;
    repeat (2) @(negedge clock);

    do_reset();
    send(0, 8'h61, 0, 0);
    send(0, 8'h62, 0, 0);
    send(0, 8'h63, 0, 0);
    model(1, 8'h00, 3, 10, nb);
    tok_is_copy = 1'b1;
    tok_offset  = AW'(3);
    tok_length  = 5'(10);
    tok_valid   = 1'b1;
    @(posedge clock);
    #1 tok_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    do_reset();
    send(0, 8'h55, 0, 0);

    repeat (2) @(negedge clock);
    chk("queue_empty", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
